lcd_update_sched: RTL and testbench

LCD_UPDATE_SCHED -- requirements
Module: lcd_update_sched

---
 rtl/lcd_pkg.sv | 47 ++++
 rtl/bin2bcd_seq.sv | 68 ++++++
 rtl/lcd_update_sched.sv | 205 ++++++++++++++++++++
 tb/tb_lcd_update_sched.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD update scheduler: driver command encodings,
// datapath opcodes, scheduler FSM states and the queued request payload.
package lcd_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned VAL_W  = 16;
  localparam int unsigned MAG_W  = 15;
  localparam int unsigned BCD_W  = 20;
  localparam int unsigned CMD_W  = 2;

  // Commands presented to the display driver
  typedef enum logic [CMD_W-1:0] {
    CMD_OFF  = 2'd0,
    CMD_IDLE = 2'd1,
    CMD_UPD  = 2'd2
  } cmd_e;

  // Datapath opcodes that can request a display update
  localparam logic [OP_W-1:0] LOAD    = 4'd0;
  localparam logic [OP_W-1:0] STORE   = 4'd1;
  localparam logic [OP_W-1:0] ADD     = 4'd2;
  localparam logic [OP_W-1:0] SUB     = 4'd3;
  localparam logic [OP_W-1:0] MUL     = 4'd4;
  localparam logic [OP_W-1:0] DIV     = 4'd5;
  localparam logic [OP_W-1:0] CMP     = 4'd6;
  localparam logic [OP_W-1:0] DISPLAY = 4'd7;

  // Scheduler FSM states
  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_PWRUP = 3'd1,
    S_IDLE  = 3'd2,
    S_CONV  = 3'd3,
    S_ISSUE = 3'd4,
    S_WAIT  = 3'd5,
    S_PWRDN = 3'd6
  } state_e;

  // Queued update request; value is sign-magnitude
  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [ADDR_W-1:0] addr;
    logic [VAL_W-1:0]  value;
  } upd_req_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 15-bit magnitude to five BCD digits.
// Ports: clk/rst (async active-high); start pulse loads mag;
// done pulses exactly 16 cycles after start; bcd holds the result
// until the next start.
module bin2bcd_seq
  import lcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MAG_W-1:0] mag,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned DIGITS  = BCD_W / 4;

  logic [MAG_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] adj_c;
  logic [BCD_W-1:0] bcd_d;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic             done_q;

  // Add-3 correction on every digit >= 5, then shift in the next binary bit
  always_comb begin
    adj_c = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_d = {adj_c[BCD_W-2:0], bin_q[MAG_W-1]};
  end

  // One shift step per cycle after start; done after the last of MAG_W steps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        bin_q <= mag;
        bcd_q <= '0;
        cnt_q <= '0;
        run_q <= 1'b1;
      end else if (run_q) begin
        bcd_q <= bcd_d;
        bin_q <= {bin_q[MAG_W-2:0], 1'b0};
        cnt_q <= cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MAG_W - 1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/lcd_update_sched.sv
// LCD update scheduler: queues datapath update requests, converts the value
// magnitude to BCD, and hands each latched payload to the display driver
// through a command/done_display handshake guarded by a watchdog.
// Ports: clk/rst (async active-high); power level; req_* valid/ready request
// input; command/opcode/addr/sign/digits to the driver; done_display from the
// driver; busy status; err sticky watchdog flag.
module lcd_update_sched
  import lcd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 8000000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              power,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_opcode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [VAL_W-1:0]  req_value,
  output logic [CMD_W-1:0]  command,
  output logic [OP_W-1:0]   opcode,
  output logic [ADDR_W-1:0] addr,
  output logic              sign,
  output logic [BCD_W-1:0]  digits,
  input  logic              done_display,
  output logic              busy,
  output logic              err
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES) + 1;

  state_e            state_q, state_d;
  cmd_e              command_q, command_d;
  logic              busy_q, busy_d;
  logic              err_q;
  logic [WDW-1:0]    wdog_q;
  logic              wd_count_c, wd_hit_c, timeout_c;

  upd_req_t          mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  upd_req_t          head_c, req_c;
  logic              empty_c, full_c, push_c, pop_c, flush_c;

  logic [OP_W-1:0]   cur_op_q, opcode_q;
  logic [ADDR_W-1:0] cur_addr_q, addr_q;
  logic              cur_sign_q, sign_q;
  logic [BCD_W-1:0]  digits_q;
  logic              conv_done;
  logic [BCD_W-1:0]  conv_bcd;

  // ---------------- request FIFO ----------------
  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign flush_c = (state_q == S_PWRDN);
  assign pop_c   = (state_q == S_IDLE) && power && !empty_c;
  // Readiness uses full alone; a same-cycle pop never frees a slot early
  assign req_ready = !full_c && power &&
                     !(state_q inside {S_OFF, S_PWRUP, S_PWRDN});
  assign push_c  = req_valid && req_ready;
  assign req_c   = '{opcode: req_opcode, addr: req_addr, value: req_value};
  assign head_c  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; power-down discards everything queued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_c) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q[AW-1:0]] <= req_c;
  end

  // Hold the in-flight request fields while the converter runs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_op_q   <= '0;
      cur_addr_q <= '0;
      cur_sign_q <= 1'b0;
    end else if (pop_c) begin
      cur_op_q   <= head_c.opcode;
      cur_addr_q <= head_c.addr;
      cur_sign_q <= head_c.value[VAL_W-1];
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (pop_c),
    .mag   (head_c.value[MAG_W-1:0]),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // ---------------- FSM ----------------
  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_OFF;
    else     state_q <= state_d;
  end

  assign wd_count_c = (state_q inside {S_PWRUP, S_ISSUE, S_WAIT, S_PWRDN});
  assign wd_hit_c   = wd_count_c && (wdog_q == WDW'(TIMEOUT_CYCLES - 1));

  // Next-state logic; a normal driver response wins over a same-cycle timeout
  always_comb begin
    state_d   = state_q;
    timeout_c = 1'b0;
    unique case (state_q)
      S_OFF:   if (power) state_d = S_PWRUP;
      S_PWRUP: begin
        if (done_display) state_d = S_IDLE;
        else if (wd_hit_c) begin state_d = S_IDLE; timeout_c = 1'b1; end
      end
      S_IDLE: begin
        if (!power)        state_d = S_PWRDN;
        else if (!empty_c) state_d = S_CONV;
      end
      S_CONV:  if (conv_done) state_d = S_ISSUE;
      S_ISSUE: begin
        if (!done_display) state_d = S_WAIT;
        else if (wd_hit_c) begin state_d = S_IDLE; timeout_c = 1'b1; end
      end
      S_WAIT: begin
        if (done_display)  state_d = S_IDLE;
        else if (wd_hit_c) begin state_d = S_IDLE; timeout_c = 1'b1; end
      end
      S_PWRDN: begin
        if (done_display)  state_d = S_OFF;
        else if (wd_hit_c) begin state_d = S_OFF; timeout_c = 1'b1; end
      end
      default: state_d = S_OFF;
    endcase
  end

  // Output decode from the next state so the registered outputs track state_q
  always_comb begin
    command_d = CMD_IDLE;
    busy_d    = 1'b1;
    unique case (state_d)
      S_OFF:   begin command_d = CMD_OFF; busy_d = 1'b0; end
      S_IDLE:  busy_d = 1'b0;
      S_ISSUE: command_d = CMD_UPD;
      S_PWRDN: command_d = CMD_OFF;
      default: ;
    endcase
  end

  // Registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      command_q <= CMD_OFF;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      command_q <= command_d;
      busy_q    <= busy_d;
      if (timeout_c) err_q <= 1'b1;
    end
  end

  // Watchdog restarts on every state change and advances in waiting states
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    wdog_q <= '0;
    else if (state_d != state_q) wdog_q <= '0;
    else if (wd_count_c)        wdog_q <= wdog_q + WDW'(1);
  end

  // Payload is captured once per update as the conversion finishes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_q <= '0;
      addr_q   <= '0;
      sign_q   <= 1'b0;
      digits_q <= '0;
    end else if ((state_q == S_CONV) && conv_done) begin
      opcode_q <= cur_op_q;
      addr_q   <= cur_addr_q;
      sign_q   <= cur_sign_q;
      digits_q <= conv_bcd;
    end
  end

  assign command = command_q;
  assign busy    = busy_q;
  assign err     = err_q;
  assign opcode  = opcode_q;
  assign addr    = addr_q;
  assign sign    = sign_q;
  assign digits  = digits_q;

endmodule

// File: tb/tb_lcd_update_sched.sv
// Bench for lcd_update_sched: directed scenarios plus random requests checked
// against a queue-based reference of accepted requests and arithmetic BCD.
module tb_lcd_update_sched;
  import lcd_pkg::*;

  localparam int unsigned TO    = 1000;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        power;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_opcode;
  logic [3:0]  req_addr;
  logic [15:0] req_value;
  logic [1:0]  command;
  logic [3:0]  opcode;
  logic [3:0]  addr;
  logic        sign;
  logic [19:0] digits;
  logic        done_display;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_err    = 0;

  upd_req_t   exp_q[$];
  upd_req_t   last;
  logic [3:0] ops [8];

  lcd_update_sched #(.TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .power        (power),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_opcode   (req_opcode),
    .req_addr     (req_addr),
    .req_value    (req_value),
    .command      (command),
    .opcode       (opcode),
    .addr         (addr),
    .sign         (sign),
    .digits       (digits),
    .done_display (done_display),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  // Decimal digits of the magnitude, least significant digit in [3:0]
  function automatic logic [19:0] bcd5(input int unsigned m);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = m;
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] op, input logic [3:0] a,
                      input logic [15:0] v, output bit acc);
    upd_req_t e;
    req_valid  = 1'b1;
    req_opcode = op;
    req_addr   = a;
    req_value  = v;
    #1;
    acc = req_ready;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (acc) begin
      e = '{opcode: op, addr: a, value: v};
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_cmd(input logic [1:0] want, input int budget, output int n);
    n = 0;
    while (command !== want && n < budget) begin
      step();
      n++;
    end
  endtask

  // Driver side: wait for CMD_UPD and compare the payload with the model head
  task automatic reach_issue(output int n);
    upd_req_t e;
    wait_cmd(CMD_UPD, 80, n);
    check("reach_upd", 32'(command), 32'(CMD_UPD));
    check("model_has_entry", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      last = e;
      check("opcode", 32'(opcode), 32'(e.opcode));
      check("addr", 32'(addr), 32'(e.addr));
      check("sign", 32'(sign), 32'(e.value[15]));
      check("digits", 32'(digits), 32'(bcd5(32'(e.value[14:0]))));
    end
    check("busy_issue", 32'(busy), 32'd1);
  endtask

  task automatic finish_issue(input int hold, input int whold);
    repeat (hold) begin
      step();
      check("upd_held", 32'(command), 32'(CMD_UPD));
    end
    done_display = 1'b0;
    step();
    check("wait_cmd", 32'(command), 32'(CMD_IDLE));
    check("wait_busy", 32'(busy), 32'd1);
    repeat (whold) step();
    done_display = 1'b1;
    step();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_cmd", 32'(command), 32'(CMD_IDLE));
    check("payload_stable", 32'(digits), 32'(bcd5(32'(last.value[14:0]))));
  endtask

  initial begin
    bit          acc;
    int          n;
    int          seen;
    logic [15:0] v;
    logic [15:0] fixed [4];

    ops = '{LOAD, STORE, ADD, SUB, MUL, DIV, CMP, DISPLAY};
    fixed = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};
    rst = 1'b1;
    power = 1'b0;
    req_valid = 1'b0;
    req_opcode = '0;
    req_addr = '0;
    req_value = '0;
    done_display = 1'b0;
    last = '0;

    // Reset state
    step();
    step();
    check("rst_command", 32'(command), 32'(CMD_OFF));
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_opcode", 32'(opcode), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_sign", 32'(sign), 32'd0);
    check("rst_digits", 32'(digits), 32'd0);
    rst = 1'b0;
    step();
    check("off_cmd", 32'(command), 32'(CMD_OFF));

    // Power-up with the driver answering after 100 cycles
    power = 1'b1;
    step();
    check("pwrup_cmd", 32'(command), 32'(CMD_IDLE));
    check("pwrup_busy", 32'(busy), 32'd1);
    check("pwrup_ready", 32'(req_ready), 32'd0);
    repeat (99) step();
    done_display = 1'b1;
    step();
    check("up_idle_busy", 32'(busy), 32'd0);
    check("up_idle_ready", 32'(req_ready), 32'd1);
    check("up_err", 32'(err), 32'd0);

    // Directed: ADD to addr 5 with +69, then -12345
    push(ADD, 4'b0101, 16'h0045, acc);
    check("dir1_acc", 32'(acc), 32'd1);
    reach_issue(n);
    check("dir1_latency", 32'(n), 32'd17);
    check("dir1_digits_abs", 32'(digits), 32'h00069);
    finish_issue(3, 2);
    push(LOAD, 4'd9, 16'hB039, acc);
    check("dir2_acc", 32'(acc), 32'd1);
    reach_issue(n);
    check("dir2_sign_abs", 32'(sign), 32'd1);
    check("dir2_digits_abs", 32'(digits), 32'h12345);
    finish_issue(1, 1);

    // Random single updates, first four are magnitude/sign boundaries
    for (int k = 0; k < 16; k++) begin
      v = (k < 4) ? fixed[k] : 16'($urandom);
      push(ops[$urandom_range(0, 7)], 4'($urandom), v, acc);
      check("rnd_acc", 32'(acc), 32'd1);
      reach_issue(n);
      check("rnd_latency", 32'(n), 32'd17);
      finish_issue($urandom_range(0, 4), $urandom_range(0, 4));
    end

    // Driver stalled in ISSUE: five back-to-back pushes against a 4-deep queue
    push(ops[$urandom_range(0, 7)], 4'($urandom), 16'($urandom), acc);
    reach_issue(n);
    for (int k = 0; k < 5; k++) begin
      bit exp_acc;
      exp_acc = (exp_q.size() < DEPTH);
      push(ops[$urandom_range(0, 7)], 4'($urandom), 16'($urandom), acc);
      check("stall_accept", 32'(acc), 32'(exp_acc));
    end
    check("stall_queued", 32'(exp_q.size()), 32'(DEPTH));
    finish_issue(2, 2);
    check("full_pop_ready", 32'(req_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      reach_issue(n);
      finish_issue($urandom_range(0, 3), $urandom_range(0, 3));
    end
    check("drained", 32'(exp_q.size()), 32'd0);

    // Power drop in WAIT with two queued
    push(ops[$urandom_range(0, 7)], 4'($urandom), 16'($urandom), acc);
    reach_issue(n);
    push(ADD, 4'd1, 16'd111, acc);
    check("pd_acc1", 32'(acc), 32'd1);
    push(SUB, 4'd2, 16'd222, acc);
    check("pd_acc2", 32'(acc), 32'd1);
    done_display = 1'b0;
    step();
    check("pd_wait_cmd", 32'(command), 32'(CMD_IDLE));
    power = 1'b0;
    done_display = 1'b1;
    step();
    check("pd_idle_cmd", 32'(command), 32'(CMD_IDLE));
    check("pd_idle_busy", 32'(busy), 32'd0);
    check("pd_idle_ready", 32'(req_ready), 32'd0);
    step();
    check("pd_pwrdn_cmd", 32'(command), 32'(CMD_OFF));
    check("pd_pwrdn_busy", 32'(busy), 32'd1);
    step();
    check("pd_off_cmd", 32'(command), 32'(CMD_OFF));
    check("pd_off_busy", 32'(busy), 32'd0);
    check("pd_payload", 32'(digits), 32'(bcd5(32'(last.value[14:0]))));
    exp_q.delete();
    power = 1'b1;
    step();
    check("pd_up_cmd", 32'(command), 32'(CMD_IDLE));
    step();
    check("pd_up_idle_busy", 32'(busy), 32'd0);
    seen = 0;
    repeat (40) begin
      step();
      if (busy !== 1'b0) seen++;
    end
    check("pd_flushed", 32'(seen), 32'd0);

    // Watchdog: driver never drops done_display
    push(ops[$urandom_range(0, 7)], 4'($urandom), 16'($urandom), acc);
    reach_issue(n);
    check("wd_err_before", 32'(err), 32'd0);
    n = 1;
    while (command === CMD_UPD && n < 1100) begin
      step();
      if (command === CMD_UPD) n++;
    end
    check("wd_issue_cycles", 32'(n), 32'(TO));
    check("wd_err", 32'(err), 32'd1);
    check("wd_idle_cmd", 32'(command), 32'(CMD_IDLE));
    check("wd_idle_busy", 32'(busy), 32'd0);
    push(ops[$urandom_range(0, 7)], 4'($urandom), 16'($urandom), acc);
    reach_issue(n);
    finish_issue(1, 1);
    check("err_sticky", 32'(err), 32'd1);

    // Reset mid-update with requests still queued
    for (int k = 0; k < 3; k++) begin
      push(ops[$urandom_range(0, 7)], 4'($urandom), 16'($urandom), acc);
      check("mid_acc", 32'(acc), 32'd1);
    end
    step();
    step();
    rst = 1'b1;
    #1;
    check("mid_rst_cmd", 32'(command), 32'(CMD_OFF));
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_rst_digits", 32'(digits), 32'd0);
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
    step();
    check("mid_pwrup_cmd", 32'(command), 32'(CMD_IDLE));
    step();
    check("mid_idle_ready", 32'(req_ready), 32'd1);
    seen = 0;
    repeat (40) begin
      step();
      if (busy !== 1'b0) seen++;
    end
    check("mid_queue_lost", 32'(seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
